// File: rtl/dither_error_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dither_error_engine                                          |
// | Description : Floyd-Steinberg error-diffusion datapath. Quantizes each     |
// |               pixel to 0/full-scale and spreads the signed error to up to  |
// |               four neighbours using SRAM read-modify-write.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dither_error_engine #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY),
    parameter int RGB_SIZE         = 8,
    parameter int THRESHOLD        = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        store_old_p,
    input  logic                        compare_and_store_n,
    input  logic [3:0]                  compute_fin,
    input  logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
    input  logic [RGB_SIZE-1:0]         q_b,
    output logic [IMAGE_ADDR_WIDTH-1:0] addr_b,
    output logic                        rden_b,
    output logic [IMAGE_ADDR_WIDTH-1:0] addr_a,
    output logic [RGB_SIZE-1:0]         data_a,
    output logic                        wren_a,
    output logic [8:0]                  quant_err,
    output logic                        pixel_done
);

    localparam int                    c_AW      = IMAGE_ADDR_WIDTH;
    localparam int                    c_XW      = $clog2(IMAGEX);
    localparam int                    c_YW      = c_AW - c_XW;
    localparam logic [RGB_SIZE-1:0]   c_PIX_MAX = {RGB_SIZE{1'b1}};
    localparam logic [RGB_SIZE-1:0]   c_THRESH  = RGB_SIZE'(THRESHOLD);
    localparam logic [c_XW-1:0]       c_X_LAST  = c_XW'(IMAGEX - 1);
    localparam logic [c_YW-1:0]       c_Y_LAST  = c_YW'(IMAGEY - 1);
    localparam logic [c_AW-1:0]       c_OFF_E   = c_AW'(1);
    localparam logic [c_AW-1:0]       c_OFF_SW  = c_AW'(IMAGEX - 1);
    localparam logic [c_AW-1:0]       c_OFF_S   = c_AW'(IMAGEX);
    localparam logic [c_AW-1:0]       c_OFF_SE  = c_AW'(IMAGEX + 1);
    localparam logic signed [12:0]    c_SUM_MAX = $signed({{(13-RGB_SIZE){1'b0}}, c_PIX_MAX});

    // registered state
    logic [c_AW-1:0]     r_base;
    logic [8:0]          r_err;
    logic                r_wr_pend;
    logic [1:0]          r_wr_sel;
    logic [c_AW-1:0]     r_wr_addr;
    logic                r_done;
    logic [c_AW-1:0]     r_addr_a;
    logic [c_AW-1:0]     r_addr_b;
    logic [RGB_SIZE-1:0] r_data_a;

    // combinational nets
    logic                w_sop;
    logic                w_cas;
    logic [3:0]          w_fin;
    logic                w_fin_any;
    logic [1:0]          w_sel;
    logic [c_XW-1:0]     w_x;
    logic [c_YW-1:0]     w_y;
    logic [3:0]          w_nb_valid;
    logic                w_sel_valid;
    logic [c_AW-1:0]     w_nb_addr;
    logic [RGB_SIZE-1:0] w_new;
    logic [8:0]          w_err;
    logic signed [12:0]  w_err_ext;
    logic signed [12:0]  w_weight;
    logic signed [12:0]  w_prod;
    logic signed [12:0]  w_term;
    logic signed [12:0]  w_sum;
    logic [RGB_SIZE-1:0] w_nb_data;
    logic                w_rden_b;
    logic [c_AW-1:0]     w_addr_b;
    logic                w_wren_a;
    logic [c_AW-1:0]     w_addr_a;
    logic [RGB_SIZE-1:0] w_data_a;

    // Strobe priority: store_old_p > compare_and_store_n > compute_fin[0..3]
    always_comb begin
        w_sop = store_old_p;
        w_cas = !store_old_p && compare_and_store_n;
        w_fin = 4'b0000;
        if (!store_old_p && !compare_and_store_n) begin
            if (compute_fin[0])      w_fin[0] = 1'b1;
            else if (compute_fin[1]) w_fin[1] = 1'b1;
            else if (compute_fin[2]) w_fin[2] = 1'b1;
            else if (compute_fin[3]) w_fin[3] = 1'b1;
        end
        w_fin_any = |w_fin;
        if (w_fin[3])      w_sel = 2'd3;
        else if (w_fin[2]) w_sel = 2'd2;
        else if (w_fin[1]) w_sel = 2'd1;
        else               w_sel = 2'd0;
    end

    // Neighbour validity and address relative to the latched base pixel
    always_comb begin
        w_x           = r_base[c_XW-1:0];
        w_y           = r_base[c_AW-1:c_XW];
        w_nb_valid[0] = (w_x != c_X_LAST);
        w_nb_valid[1] = (w_x != '0) && (w_y != c_Y_LAST);
        w_nb_valid[2] = (w_y != c_Y_LAST);
        w_nb_valid[3] = (w_x != c_X_LAST) && (w_y != c_Y_LAST);
        w_sel_valid   = w_nb_valid[w_sel];
        case (w_sel)
            2'd0:    w_nb_addr = r_base + c_OFF_E;
            2'd1:    w_nb_addr = r_base + c_OFF_SW;
            2'd2:    w_nb_addr = r_base + c_OFF_S;
            default: w_nb_addr = r_base + c_OFF_SE;
        endcase
    end

    // Quantize the current pixel and form the weighted, clamped neighbour update
    always_comb begin
        w_new     = (q_b >= c_THRESH) ? c_PIX_MAX : '0;
        w_err     = {1'b0, q_b} - {1'b0, w_new};
        w_err_ext = {{4{r_err[8]}}, r_err};
        case (r_wr_sel)
            2'd0:    w_weight = 13'sd7;
            2'd1:    w_weight = 13'sd3;
            2'd2:    w_weight = 13'sd5;
            default: w_weight = 13'sd1;
        endcase
        w_prod = w_err_ext * w_weight;
        w_term = w_prod >>> 4;
        w_sum  = $signed({{(13-RGB_SIZE){1'b0}}, q_b}) + w_term;
        if (w_sum < 13'sd0)          w_nb_data = '0;
        else if (w_sum > c_SUM_MAX)  w_nb_data = c_PIX_MAX;
        else                         w_nb_data = w_sum[RGB_SIZE-1:0];
    end

    // SRAM port drive; a pending neighbour write owns port A, reset silences both ports
    always_comb begin
        w_rden_b = 1'b0;
        w_addr_b = r_addr_b;
        w_wren_a = 1'b0;
        w_addr_a = r_addr_a;
        w_data_a = r_data_a;
        if (rst) begin
            w_addr_b = '0;
            w_addr_a = '0;
            w_data_a = '0;
        end else begin
            if (w_sop) begin
                w_rden_b = 1'b1;
                w_addr_b = png_idx;
            end else if (w_fin_any && w_sel_valid) begin
                w_rden_b = 1'b1;
                w_addr_b = w_nb_addr;
            end
            if (r_wr_pend) begin
                w_wren_a = 1'b1;
                w_addr_a = r_wr_addr;
                w_data_a = w_nb_data;
            end else if (w_cas) begin
                w_wren_a = 1'b1;
                w_addr_a = r_base;
                w_data_a = w_new;
            end
        end
    end

    // Pixel context, pending write slot and held port values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_err     <= '0;
            r_wr_pend <= 1'b0;
            r_wr_sel  <= 2'd0;
            r_wr_addr <= '0;
            r_done    <= 1'b0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_data_a  <= '0;
        end else begin
            r_addr_a  <= w_addr_a;
            r_addr_b  <= w_addr_b;
            r_data_a  <= w_data_a;
            if (w_sop) r_base <= png_idx;
            if (w_cas) r_err  <= w_err;
            r_wr_pend <= w_fin_any && w_sel_valid;
            r_wr_sel  <= w_sel;
            r_wr_addr <= w_nb_addr;
            r_done    <= w_fin[3];
        end
    end

    assign addr_b     = w_addr_b;
    assign rden_b     = w_rden_b;
    assign addr_a     = w_addr_a;
    assign data_a     = w_data_a;
    assign wren_a     = w_wren_a;
    assign quant_err  = r_err;
    assign pixel_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dither_error_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dither_error_engine                                       |
// | Description : Self-checking bench for dither_error_engine with an SRAM     |
// |               model and a Floyd-Steinberg reference image.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dither_error_engine;

    localparam int IMAGEX = 64;
    localparam int IMAGEY = 64;
    localparam int AW     = 12;
    localparam int NPIX   = IMAGEX * IMAGEY;

    logic          clk = 1'b0;
    logic          rst;
    logic          store_old_p;
    logic          compare_and_store_n;
    logic [3:0]    compute_fin;
    logic [AW-1:0] png_idx;
    logic [7:0]    q_b;
    logic [AW-1:0] addr_b;
    logic          rden_b;
    logic [AW-1:0] addr_a;
    logic [7:0]    data_a;
    logic          wren_a;
    logic [8:0]    quant_err;
    logic          pixel_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem     [NPIX];
    int         ref_img [NPIX];
    int         exp_ra[$];
    int         exp_wa[$];
    int         exp_wd[$];

    dither_error_engine #(
        .IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .IMAGE_ADDR_WIDTH(AW),
        .RGB_SIZE(8), .THRESHOLD(128)
    ) dut (
        .clk(clk), .rst(rst), .store_old_p(store_old_p),
        .compare_and_store_n(compare_and_store_n), .compute_fin(compute_fin),
        .png_idx(png_idx), .q_b(q_b), .addr_b(addr_b), .rden_b(rden_b),
        .addr_a(addr_a), .data_a(data_a), .wren_a(wren_a),
        .quant_err(quant_err), .pixel_done(pixel_done)
    );

    always #5 clk = ~clk;

    // SRAM: read-first, 1-cycle read latency
    always @(posedge clk) begin
        if (rden_b) q_b <= mem[addr_b];
        if (wren_a) mem[addr_a] = data_a;
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference Floyd-Steinberg step; queues the SRAM traffic the pixel must cause.
    // nrd/nwr limit how many neighbour reads/writes actually happen (reset abort).
    task automatic model_pixel(input int idx, input int nrd, input int nwr, output int err_o);
        int off[4];
        int wt[4];
        bit ok[4];
        int x, y, old, nw, p, term, v;
        off = '{1, IMAGEX - 1, IMAGEX, IMAGEX + 1};
        wt  = '{7, 3, 5, 1};
        x   = idx % IMAGEX;
        y   = idx / IMAGEX;
        old = ref_img[idx];
        nw  = (old >= 128) ? 255 : 0;
        err_o = old - nw;
        exp_ra.push_back(idx);
        exp_wa.push_back(idx);
        exp_wd.push_back(nw);
        ref_img[idx] = nw;
        ok[0] = (x < IMAGEX - 1);
        ok[1] = (x > 0) && (y < IMAGEY - 1);
        ok[2] = (y < IMAGEY - 1);
        ok[3] = (x < IMAGEX - 1) && (y < IMAGEY - 1);
        for (int j = 0; j < 4; j++) begin
            if (ok[j] && j < nrd) exp_ra.push_back(idx + off[j]);
            if (ok[j] && j < nwr) begin
                p    = err_o * wt[j];
                term = (p >= 0) ? p / 16 : -((-p + 15) / 16);
                v    = ref_img[idx + off[j]] + term;
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
                ref_img[idx + off[j]] = v;
                exp_wa.push_back(idx + off[j]);
                exp_wd.push_back(v);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            store_old_p = 1'b0; compare_and_store_n = 1'b0; compute_fin = 4'b0000;
        end
    endtask

    task automatic do_pixel(input int idx, input bit abort, input int ovl_addr);
        int e;
        model_pixel(idx, abort ? 2 : 4, abort ? 1 : 4, e);
        @(posedge clk); #1;
        store_old_p = 1'b1; compare_and_store_n = 1'b0; compute_fin = 4'b0000;
        png_idx = AW'(idx);
        if (ovl_addr >= 0) begin
            @(negedge clk);
            check("ovl_wren_a", wren_a, 1);
            check("ovl_addr_a", addr_a, ovl_addr);
            check("ovl_rden_b", rden_b, 1);
            check("ovl_addr_b", addr_b, idx);
        end
        @(posedge clk); #1; store_old_p = 1'b0; compare_and_store_n = 1'b1;
        @(posedge clk); #1; compare_and_store_n = 1'b0; compute_fin = 4'b0001;
        check("quant_err", $signed(quant_err), e);
        @(posedge clk); #1; compute_fin = 4'b0010;
        @(posedge clk); #1; compute_fin = 4'b0100;
        if (abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; compute_fin = 4'b0000;
            check("rst_wren_a", wren_a, 0);
            check("rst_rden_b", rden_b, 0);
            check("rst_addr_a", addr_a, 0);
            check("rst_addr_b", addr_b, 0);
            check("rst_data_a", data_a, 0);
            check("rst_quant_err", quant_err, 0);
            check("rst_pixel_done", pixel_done, 0);
        end else begin
            @(posedge clk); #1; compute_fin = 4'b1000;
        end
    endtask

    // Transaction compare: every DUT port access must match the model's queues
    initial begin : cmp
        bit prev_fin3;
        bit prev_rst;
        int a;
        int d;
        prev_fin3 = 1'b0;
        prev_rst  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("wren_a_in_reset", wren_a, 0);
            end else begin
                if (wren_a) begin
                    if (exp_wa.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL write: got unexpected write addr %0d data %0d expected none at %0t", addr_a, data_a, $time);
                    end else begin
                        a = exp_wa.pop_front();
                        d = exp_wd.pop_front();
                        check("write_addr", addr_a, a);
                        check("write_data", data_a, d);
                    end
                end
                if (rden_b) begin
                    if (exp_ra.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL read: got unexpected read addr %0d expected none at %0t", addr_b, $time);
                    end else begin
                        a = exp_ra.pop_front();
                        check("read_addr", addr_b, a);
                    end
                end
                check("pixel_done", pixel_done, (prev_fin3 && !prev_rst) ? 1 : 0);
            end
            prev_fin3 = compute_fin[3] && !store_old_p && !compare_and_store_n && (compute_fin[2:0] == 3'b000);
            prev_rst  = rst;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int idx, prev, gap, bad, first_bad;
        rst = 1'b1; store_old_p = 1'b0; compare_and_store_n = 1'b0;
        compute_fin = 4'b0000; png_idx = '0;
        for (int i = 0; i < NPIX; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
            ref_img[i] = int'(mem[i]);
        end
        mem[0]  = 8'd200; mem[1]  = 8'd100; mem[64] = 8'd100; mem[65] = 8'd100;
        mem[5]  = 8'd100; mem[6]  = 8'd250;
        mem[10] = 8'd127; mem[11] = 8'd200;
        mem[20] = 8'd128; mem[21] = 8'd10;
        foreach (mem[i]) ref_img[i] = int'(mem[i]);

        repeat (3) @(posedge clk);
        #1;
        check("reset_wren_a", wren_a, 0);
        check("reset_rden_b", rden_b, 0);
        check("reset_addr_a", addr_a, 0);
        check("reset_addr_b", addr_b, 0);
        check("reset_data_a", data_a, 0);
        check("reset_quant_err", quant_err, 0);
        check("reset_pixel_done", pixel_done, 0);
        rst = 1'b0;

        do_pixel(0, 1'b0, -1);
        idle(2);
        check("px0_self", mem[0], 255);
        check("px0_n0", mem[1], 75);
        check("px0_n2", mem[64], 82);
        check("px0_n3", mem[65], 96);
        check("px0_err", $signed(quant_err), -55);

        do_pixel(5, 1'b0, -1);
        idle(2);
        check("clamp_high", mem[6], 255);
        check("err_pos", $signed(quant_err), 100);

        do_pixel(10, 1'b0, -1);
        idle(2);
        check("err127_n0", mem[11], 255);
        check("err_127", $signed(quant_err), 127);
        do_pixel(20, 1'b0, -1);
        idle(2);
        check("clamp_low", mem[21], 0);
        check("err_m127", $signed(quant_err), -127);

        do_pixel(4040, 1'b0, -1);
        idle(2);
        do_pixel(4095, 1'b0, -1);
        idle(3);

        do_pixel(2, 1'b0, -1);
        do_pixel(3, 1'b0, 67);
        idle(2);

        do_pixel(130, 1'b1, -1);
        idle(2);
        check("abort_wq_empty", exp_wa.size(), 0);
        check("abort_rq_empty", exp_ra.size(), 0);

        prev = -1000;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 2);
            do begin
                idx = $urandom_range(0, NPIX - 1);
            end while (gap == 0 && idx == prev + IMAGEX + 1);
            if (gap != 0) idle(gap);
            do_pixel(idx, 1'b0, -1);
            prev = idx;
        end
        idle(4);

        check("final_wq_empty", exp_wa.size(), 0);
        check("final_rq_empty", exp_ra.size(), 0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (int'(mem[i]) != ref_img[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            $display("first differing pixel %0d: sram %0d model %0d", first_bad, mem[first_bad], ref_img[first_bad]);
        check("image_mismatches", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dither_error_engine.md
Name: dither_error_engine

Overview:
- Floyd-Steinberg datapath stage directly downstream of the dithering loop controller.
- Consumes the controller's per-pixel strobes (store_old_p, compare_and_store_n, compute_fin[3:0]) and png_idx.
- Drives the image SRAM: port A is write-only, port B is read-only with 1-cycle read latency.
- For each pixel it quantizes the pixel to 0/255 and diffuses the signed error to up to four neighbours using read-modify-write.

Parameters:
- IMAGEX, 64, image width in pixels; must be a power of two.
- IMAGEY, 64, image height in pixels.
- IMAGE_ADDR_WIDTH, $clog2(IMAGEX*IMAGEY), SRAM address width.
- RGB_SIZE, 8, pixel width; grayscale intensity.
- THRESHOLD, 128, quantize threshold: old >= THRESHOLD gives 255, otherwise 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- store_old_p  in  1  read-current-pixel strobe
- compare_and_store_n  in  1  quantize/write strobe
- compute_fin  in  4  one-hot neighbour strobe; bit j selects neighbour j
- png_idx  in  IMAGE_ADDR_WIDTH  current pixel index, row-major
- q_b  in  RGB_SIZE  SRAM port B read data; valid 1 cycle after rden_b
- addr_b  out  IMAGE_ADDR_WIDTH  SRAM port B read address
- rden_b  out  1  SRAM port B read enable
- addr_a  out  IMAGE_ADDR_WIDTH  SRAM port A write address
- data_a  out  RGB_SIZE  SRAM port A write data
- wren_a  out  1  SRAM port A write enable
- quant_err  out  9  signed error of the last quantized pixel (debug)
- pixel_done  out  1  1-cycle pulse when the pixel's last neighbour write slot completes

Behaviour:
- Reset is synchronous and active-high (rst sampled on posedge clk); the design has a single clock, clk. All registers clear on reset. Outputs after reset: wren_a=0, rden_b=0, addr_a=0, addr_b=0, data_a=0, quant_err=0, pixel_done=0.
- Reset mid-pixel discards any pending read-modify-write; no write is issued after rst.
- Strobes are mutually exclusive. If more than one is high, priority is store_old_p > compare_and_store_n > compute_fin[0..3]; the other strobes are ignored that cycle.
- Coordinates are x = png_idx[log2(IMAGEX)-1:0] and y = png_idx >> log2(IMAGEX).
- store_old_p, cycle t:
  - latch base = png_idx and its x/y.
  - rden_b=1, addr_b=png_idx.
- compare_and_store_n, cycle t+1:
  - old = q_b; new = (old >= THRESHOLD) ? 255 : 0.
  - err = old - new as 9-bit signed, range -127..+127; register it to quant_err.
  - wren_a=1, addr_a=base, data_a=new in the same cycle.
- Neighbour table, j: offset, weight, valid when:
  - 0: +1, 7, x < IMAGEX-1
  - 1: +IMAGEX-1, 3, x > 0 and y < IMAGEY-1
  - 2: +IMAGEX, 5, y < IMAGEY-1
  - 3: +IMAGEX+1, 1, x < IMAGEX-1 and y < IMAGEY-1
- Neighbour j read (cycle of compute_fin[j]):
  - if valid: rden_b=1, addr_b=base+offset, and set pending[j].
  - if invalid: no read, pending[j] stays 0.
- Neighbour j write (exactly the next cycle, independent of which strobe is then active):
  - if pending[j]: term = (err*weight) >>> 4, arithmetic floor shift, computed at 13-bit signed.
  - sum = q_b + term, clamped to [0,255].
  - wren_a=1, addr_a=base+offset, data_a=sum.
- Neighbour 3's write lands in the cycle after compute_fin[3], which is the next pixel's store_old_p cycle.
  - That cycle's read address (the next pixel) never equals the write address; no forwarding is required.
  - base is updated only after that write uses the old base (register semantics).
- pixel_done pulses in the cycle after compute_fin[3], whether or not neighbour 3 was valid.
- Per-pixel latency: 6 strobe cycles plus 1 trailing write cycle, which overlaps the next pixel.
- The last pixel (IMAGEX-1, IMAGEY-1) has no valid neighbours, so no trailing write occurs after the image ends.
- When no strobe is active and no write is pending: wren_a=0, rden_b=0, and addresses hold their last values.

Test Plan:
- Pixel idx0=200, idx1=100, idx64=100, idx65=100; run one pixel sequence.
  - Expect idx0 := 255, quant_err = -55.
  - Expect idx1 := 75, idx64 := 82, idx65 := 96.
  - No access to idx 63 or any address on neighbour 1 (x=0).
- Pixel idx5=100 (quantizes to 0, err=+100), neighbour idx6=250 -> write 255 (clamp high, 293).
- Pixel old=127 (err=+127), neighbour 0 value 200 -> term 55, write 255. Pixel old=128 (err=-127), neighbour 0 value 10 -> term -56, write 0 (clamp low).
- Last-row pixel idx 4040 -> only the neighbour-0 write occurs. Pixel idx 4095 -> only the self write; no pixel_done-cycle write.
- Back-to-back pixels idx 2 and 3, with idx 2's neighbour 3 write coinciding with idx 3's store_old_p:
  - Expect the write to idx 67 and the read of idx 3 in the same cycle.
  - Expect the idx 3 result to use its updated value from idx 2's neighbour-0 write.
- Assert rst during the cycle after compute_fin[1] -> no wren_a in that or any following cycle; all outputs 0 the next cycle.
